// File: rtl/ahb_clac_master.sv
// AHB-Lite master that sequences one calculator run: three operand writes and one result read.
// Optional data-phase wait timeout is enabled with CLAC_MST_TIMEOUT_EN.
module ahb_clac_master #(
  parameter logic [7:0] ADDR_A    = 8'h00,
  parameter logic [7:0] ADDR_B    = 8'h04,
  parameter logic [7:0] ADDR_CTRL = 8'h08,
  parameter logic [7:0] ADDR_RES  = 8'h0C,
  parameter int         TIMEOUT   = 16
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [1:0]  mode,
  output logic        hsel,
  output logic [7:0]  haddr,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic        hready_resp,
  input  logic [1:0]  hresp,
  input  logic [31:0] hrdata,
  output logic [31:0] result,
  output logic        done,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    A_PH,
    LAST_D,
    FIN,
    ABORT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [1:0]  mode_q;
  logic [31:0] result_q;
  logic        accept;
  logic        cap;
  logic        aph;
  logic        in_dph;
  logic        bus_err;
  logic        tmo;

  assign accept  = (state_q == IDLE) && start;
  assign aph     = (state_q == A_PH);
  // Index 0 has no earlier transfer, so no data phase runs beside it.
  assign in_dph  = (aph && (idx_q != 2'd0)) ||
                   (state_q == LAST_D);
  assign bus_err = in_dph && (hresp == 2'b01) &&
                   !hready_resp;

`ifdef CLAC_MST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wait_q <= '0;
    end else if (in_dph && !hready_resp) begin
      wait_q <= wait_q + 1'b1;
    end else begin
      wait_q <= '0;
    end
  end

  assign tmo = in_dph && !hready_resp &&
               (wait_q == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign tmo            = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
    end else if (accept) begin
      a_q    <= op_a;
      b_q    <= op_b;
      mode_q <= mode;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      result_q <= '0;
    end else if (cap) begin
      result_q <= hrdata;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = A_PH;
          idx_d   = 2'd0;
        end
      end
      A_PH: begin
        if (bus_err || tmo) begin
          state_d = ABORT;
        end else if (hready_resp) begin
          if (idx_q == 2'd3) begin
            state_d = LAST_D;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      LAST_D: begin
        if (bus_err || tmo) begin
          state_d = ABORT;
        end else if (hready_resp) begin
          cap     = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    haddr = 8'h00;
    unique case (1'b1)
      aph && (idx_q == 2'd0): haddr = ADDR_A;
      aph && (idx_q == 2'd1): haddr = ADDR_B;
      aph && (idx_q == 2'd2): haddr = ADDR_CTRL;
      aph && (idx_q == 2'd3): haddr = ADDR_RES;
      default:                haddr = 8'h00;
    endcase
  end

  // Write data trails its address phase by one transfer.
  always_comb begin
    hwdata = 32'h0;
    unique case (1'b1)
      aph && (idx_q == 2'd1): hwdata = {16'h0, a_q};
      aph && (idx_q == 2'd2): hwdata = {16'h0, b_q};
      aph && (idx_q == 2'd3): hwdata = {29'h0, mode_q, 1'b1};
      default:                hwdata = 32'h0;
    endcase
  end

  assign htrans = aph ? 2'b10 : 2'b00;
  assign hsize  = aph ? 3'b010 : 3'b000;
  assign hburst = 3'b000;
  assign hwrite = aph && (idx_q != 2'd3);
  assign hsel   = aph || (state_q == LAST_D);
  assign busy   = hsel;
  assign done   = (state_q == FIN) || (state_q == ABORT);
  assign err    = (state_q == ABORT);
  assign result = result_q;

endmodule

// File: doc/ahb_clac_master.md
AHB_CLAC_MASTER -- requirements
Module: ahb_clac_master

Interface
REQ-001 Parameter ADDR_A, default 8'h00, address of the opcode_a register.
REQ-002 Parameter ADDR_B, default 8'h04, address of the opcode_b register.
REQ-003 Parameter ADDR_CTRL, default 8'h08, address of the control register (bit0 ctrl, bits[2:1] clac_mode).
REQ-004 Parameter ADDR_RES, default 8'h0C, address of the 32-bit result register.
REQ-005 Parameter TIMEOUT, default 16, maximum wait-state cycles per data phase (used only with the Configuration macro).
REQ-006 hclk  input  1  clock; all state updates on the rising edge.
REQ-007 hresetn  input  1  reset, asynchronous and active-low.
REQ-008 start  input  1  one-cycle request to run one calculation; sampled only in IDLE.
REQ-009 op_a, op_b  input  16 each  operands; captured when start is accepted.
REQ-010 mode  input  2  calculation mode; captured when start is accepted.
REQ-011 hsel  output  1  slave select.
REQ-012 haddr  output  8  AHB address.
REQ-013 hwrite  output  1  1 = write, 0 = read.
REQ-014 htrans, hsize, hburst  output  2, 3, 3  AHB transfer controls.
REQ-015 hwdata  output  32  write data.
REQ-016 hready_resp  input  1  slave ready; low extends the current data phase.
REQ-017 hresp  input  2  slave response; 2'b00 OKAY, 2'b01 ERROR.
REQ-018 hrdata  input  32  read data.
REQ-019 result  output  32  captured result.
REQ-020 done  output  1  one-cycle completion pulse.
REQ-021 err  output  1  one-cycle pulse, concurrent with done, on ERROR or timeout.
REQ-022 busy  output  1  high from start acceptance until the cycle before done.

Function
REQ-023 States: IDLE, A_PH (address phase of transfer n with data phase of n-1), LAST_D (data phase of the read), FIN, ABORT.
REQ-024 The sequence is four single pipelined transfers: write ADDR_A, write ADDR_B, write ADDR_CTRL, read ADDR_RES.
REQ-025 Every transfer uses htrans=2'b10 (NONSEQ), hsize=3'b010, hburst=3'b000; when no address phase is active, htrans=2'b00 and haddr=0.
REQ-026 Write data: {16'h0,op_a}, {16'h0,op_b}, {29'h0,mode,1'b1}, each driven in the data phase following its address phase.
REQ-027 With zero wait states, start is high at edge 0: address phases occupy cycles 1-4, data phases cycles 2-5, result is captured at the end of cycle 5, and done is high in cycle 6 (latency 6).
REQ-028 hsel is high from the first address phase through the last data phase, otherwise low.
REQ-029 While hready_resp=0, haddr, htrans, hwrite and hwdata hold their values and the sequence does not advance.
REQ-030 An ERROR response (hresp=01 with hready_resp=0) drives htrans=IDLE in the next cycle, cancelling the pending transfer, and enters ABORT; done and err pulse together one cycle later; result is not updated.
REQ-031 start asserted outside IDLE is ignored; a start in the cycle done is high is ignored.
REQ-032 FIN/ABORT return to IDLE after one cycle; result holds its value until the next successful read.

Reset
REQ-033 On hresetn low, all outputs immediately become 0 (htrans=IDLE, hsel=0, result=0, done=err=busy=0), the FSM enters IDLE, and any in-flight sequence is dropped without done.

Configuration
REQ-034 With CLAC_MST_TIMEOUT_EN defined, a counter counts consecutive hready_resp=0 cycles in a data phase; reaching TIMEOUT forces htrans=IDLE and ABORT, with done and err pulsed.
REQ-035 Without CLAC_MST_TIMEOUT_EN defined, no counter exists and the master waits indefinitely.

Verification
REQ-036 Scenario: op_a=16'h0003, op_b=16'h0005, mode=0, zero waits -> haddr sequence 00,04,08,0C in cycles 1-4; hwdata 3,5,1 in cycles 2-4; hrdata=32'h8 in cycle 5 -> result=8 and done=1 in cycle 6.
REQ-037 Scenario: hready_resp=0 for 2 cycles during the ADDR_B data phase -> all bus outputs are held, and done moves to cycle 8.
REQ-038 Scenario: ERROR response on the ADDR_CTRL write -> htrans=IDLE the next cycle, no read is issued, done=err=1 together, result is unchanged.
REQ-039 Scenario: second start pulse in cycle 3 -> ignored; exactly one done pulse occurs.
REQ-040 Scenario: hresetn low in cycle 3 -> outputs are 0 immediately and no done pulse; a fresh start after release completes normally.
REQ-041 Scenario (macro defined, TIMEOUT=4): hready_resp held at 0 -> abort after 4 wait cycles with done=err=1.
